// File: rtl/operand_feeder.sv
// Operand feeder: packs 64 byte pairs into the A/B lane vectors of a dot-product core,
// waits CORE_LAT cycles, then holds the captured result. Option: OPERAND_FEEDER_SHORT_FRAME_EN.
module operand_feeder #(
   parameter int unsigned CORE_LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_a,
   input  logic [7:0]         in_b,
   input  logic               in_last,
   output logic [511:0]       A_VEC,
   output logic [511:0]       B_VEC,
   input  logic signed [23:0] core_result,
   output logic               res_valid,
   input  logic               res_ready,
   output logic signed [23:0] res_data,
   output logic               busy
);

   localparam int unsigned LANE_CNT_W = 6;
   localparam int unsigned WAIT_W     = (CORE_LAT < 1) ? 1 : $clog2(CORE_LAT + 1);
   localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(63);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_d;
   logic [LANE_CNT_W-1:0]   lane_cnt;
   logic [LANE_CNT_W-1:0]   lane_d;
   logic [WAIT_W-1:0]       wait_cnt;
   logic                    accept;
   logic                    frame_end;
   logic                    wait_done;
   logic                    res_hs;
   logic                    in_ready_d;
   logic                    res_valid_d;
   logic                    busy_d;

   // in_ready/res_valid are only ever high in LOAD/RESP, so the two handshakes are exclusive
   assign accept    = in_valid && in_ready && (state == LOAD);
   assign res_hs    = res_valid && res_ready && (state == RESP);
   assign wait_done = (wait_cnt == WAIT_W'(CORE_LAT));

`ifdef OPERAND_FEEDER_SHORT_FRAME_EN
   assign frame_end = (lane_cnt == LAST_LANE) || in_last;
`else
   assign frame_end = (lane_cnt == LAST_LANE);
   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

   // State register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= LOAD;
      else       state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         LOAD:    if (accept && frame_end) state_d = WAIT;
         WAIT:    if (wait_done)           state_d = RESP;
         RESP:    if (res_hs)              state_d = LOAD;
         default:                          state_d = LOAD;
      endcase
   end

   // Output/next-value logic; the lane counter parks on the final lane until the result drains
   always_comb begin
      lane_d = lane_cnt;
      if (res_hs)                     lane_d = '0;
      else if (accept && !frame_end)  lane_d = lane_cnt + LANE_CNT_W'(1);
      in_ready_d  = (state_d == LOAD);
      res_valid_d = (state_d == RESP);
      busy_d      = (state_d != LOAD) || (lane_d != '0);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         lane_cnt  <= '0;
         wait_cnt  <= '0;
         A_VEC     <= '0;
         B_VEC     <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         lane_cnt  <= lane_d;
         in_ready  <= in_ready_d;
         res_valid <= res_valid_d;
         busy      <= busy_d;
         if (accept) begin
            A_VEC[{lane_cnt, 3'b000} +: 8] <= in_a;
            B_VEC[{lane_cnt, 3'b000} +: 8] <= in_b;
            wait_cnt <= '0;
         end
         if (state == WAIT) begin
            if (wait_done) res_data <= core_result;
            else           wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (res_hs) begin
            A_VEC <= '0;
            B_VEC <= '0;
         end
      end
   end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed self-checking bench for operand_feeder with a pipelined reference dot-product core.
module tb_operand_feeder;

   localparam int unsigned CORE_LAT = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [7:0]         in_a = 8'h00;
   logic [7:0]         in_b = 8'h00;
   logic               in_last = 1'b0;
   logic [511:0]       A_VEC;
   logic [511:0]       B_VEC;
   logic signed [23:0] core_result;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic signed [23:0] res_data;
   logic               busy;

   logic [23:0]        dot;
   logic [23:0]        pipe1;
   logic [23:0]        pipe2;

   int errors = 0;
   int checks = 0;

   operand_feeder #(.CORE_LAT(CORE_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_last     (in_last),
      .A_VEC       (A_VEC),
      .B_VEC       (B_VEC),
      .core_result (core_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Core model: unsigned byte dot product, two register stages
   always_comb begin
      dot = '0;
      for (int k = 0; k < 64; k++)
         dot = dot + 24'(A_VEC[k*8 +: 8]) * 24'(B_VEC[k*8 +: 8]);
   end

   always_ff @(posedge clk) begin
      pipe1 <= dot;
      pipe2 <= pipe1;
   end

   assign core_result = $signed(pipe2);

   // Offer one pair from a negedge; returns on the negedge after the accepting edge
   task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_pair_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!res_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      if (!res_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_result_timeout: res_valid=0, required 1 within 30 cycles");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (A_VEC !== '0) begin errors++; $display("FAIL reset_a_vec: got %h required 0", A_VEC); end
      checks++; if (B_VEC !== '0) begin errors++; $display("FAIL reset_b_vec: got %h required 0", B_VEC); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b required 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
      checks++; if (res_data !== 24'sd0) begin errors++; $display("FAIL reset_res_data: got %0d required 0", res_data); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %0b required 1", in_ready); end
   endtask

   task automatic test_full_frame();
      res_ready = 1'b1;
      send_pair(8'd1, 8'd1, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_first: got %0b required 1", busy); end
      for (int k = 1; k < 64; k++) send_pair(8'd1, 8'd1, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_wait: got %0b required 0", in_ready); end
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 1) @(negedge clk);
         checks++;
         if (res_valid !== (c == 3)) begin
            errors++;
            $display("FAIL full_rise_cycle%0d: res_valid=%0b required %0b", c, res_valid, (c == 3));
         end
      end
      checks++; if (res_data !== 24'sd64) begin errors++; $display("FAIL full_res_data: got %0d required 64", res_data); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL full_res_valid_clear: got %0b required 0", res_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_back: got %0b required 1", in_ready); end
      checks++; if (A_VEC !== '0) begin errors++; $display("FAIL full_a_vec_clear: got %h required 0", A_VEC); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_idle: got %0b required 0", busy); end
      checks++; if (res_data !== 24'sd64) begin errors++; $display("FAIL full_res_data_kept: got %0d required 64", res_data); end
   endtask

   task automatic test_lane_order();
      int cyc;
      res_ready = 1'b1;
      for (int k = 0; k < 64; k++) send_pair(8'(k), 8'd1, 1'b0);
      checks++; if (A_VEC[7:0] !== 8'h00) begin errors++; $display("FAIL lane_a_low: got %h required 00", A_VEC[7:0]); end
      checks++; if (A_VEC[511:504] !== 8'h3F) begin errors++; $display("FAIL lane_a_high: got %h required 3f", A_VEC[511:504]); end
      checks++; if (B_VEC !== {64{8'h01}}) begin errors++; $display("FAIL lane_b_all: got %h required all 01", B_VEC); end
      wait_result(cyc);
      checks++; if (res_data !== 24'sd2016) begin errors++; $display("FAIL lane_res_data: got %0d required 2016", res_data); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int cyc;
      res_ready = 1'b0;
      for (int k = 0; k < 64; k++) send_pair(8'd2, 8'd1, 1'b0);
      wait_result(cyc);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a     = 8'hFF;
         in_b     = 8'hFF;
         @(negedge clk);
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid%0d: got %0b required 1", i, res_valid); end
         checks++; if (res_data !== 24'sd128) begin errors++; $display("FAIL bp_res_data%0d: got %0d required 128", i, res_data); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %0b required 0", i, in_ready); end
         checks++; if (A_VEC[7:0] !== 8'h02) begin errors++; $display("FAIL bp_a_hold%0d: got %h required 02", i, A_VEC[7:0]); end
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %0b required 1", in_ready); end
      checks++; if (A_VEC !== '0) begin errors++; $display("FAIL bp_a_vec_clear: got %h required 0", A_VEC); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_res_valid_clear: got %0b required 0", res_valid); end
      checks++; if (res_data !== 24'sd128) begin errors++; $display("FAIL bp_res_data_kept: got %0d required 128", res_data); end
   endtask

   task automatic test_reset_mid_frame();
      int cyc;
      res_ready = 1'b1;
      for (int k = 0; k < 20; k++) send_pair(8'd5, 8'd7, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0b required 1", busy); end
      rst_n = 1'b1;
      #1;
      checks++; if (A_VEC !== '0) begin errors++; $display("FAIL mid_a_vec: got %h required 0", A_VEC); end
      checks++; if (B_VEC !== '0) begin errors++; $display("FAIL mid_b_vec: got %h required 0", B_VEC); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b required 0", busy); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_res_valid: got %0b required 0", res_valid); end
      checks++; if (res_data !== 24'sd0) begin errors++; $display("FAIL mid_res_data: got %0d required 0", res_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 64; k++) send_pair(8'd1, 8'd1, 1'b0);
      wait_result(cyc);
      checks++; if (res_data !== 24'sd64) begin errors++; $display("FAIL mid_next_frame: got %0d required 64", res_data); end
      @(negedge clk);
   endtask

   task automatic test_short_frame();
      int cyc;
      res_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_pair(8'd2, 8'd3, 1'b0);
      send_pair(8'd2, 8'd3, 1'b1);
`ifdef OPERAND_FEEDER_SHORT_FRAME_EN
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL short_in_ready: got %0b required 0", in_ready); end
      checks++; if (A_VEC[39:32] !== 8'h00) begin errors++; $display("FAIL short_lane4_zero: got %h required 00", A_VEC[39:32]); end
      wait_result(cyc);
      checks++; if (res_data !== 24'sd24) begin errors++; $display("FAIL short_res_data: got %0d required 24", res_data); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL short_in_ready_after: got %0b required 1", in_ready); end
`else
      begin
         logic seen = 1'b0;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL short_in_ready: got %0b required 1", in_ready); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy: got %0b required 1", busy); end
         checks++; if (A_VEC[31:24] !== 8'h02) begin errors++; $display("FAIL short_lane3: got %h required 02", A_VEC[31:24]); end
         for (int k = 4; k < 64; k++) begin
            if (res_valid) seen = 1'b1;
            send_pair(8'd2, 8'd3, (k == 10));
         end
         checks++; if (seen !== 1'b0) begin errors++; $display("FAIL short_no_early_result: got %0b required 0", seen); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL short_in_ready_end: got %0b required 0", in_ready); end
         wait_result(cyc);
         checks++; if (cyc !== 3) begin errors++; $display("FAIL short_latency: got %0d required 3", cyc); end
         checks++; if (res_data !== 24'sd384) begin errors++; $display("FAIL short_res_data: got %0d required 384", res_data); end
         @(negedge clk);
      end
`endif
   endtask

   task automatic test_gapped();
      logic [7:0]   av[64];
      logic [7:0]   bv[64];
      logic [511:0] exp_a;
      logic [511:0] exp_b;
      int           exp_sum = 0;
      int           cyc;
      res_ready = 1'b1;
      for (int k = 0; k < 64; k++) begin
         av[k] = 8'(k * 37 + 11);
         bv[k] = 8'(k * 13 + 200);
         exp_a[k*8 +: 8] = av[k];
         exp_b[k*8 +: 8] = bv[k];
         exp_sum += int'(av[k]) * int'(bv[k]);
      end
      for (int k = 0; k < 64; k++) begin
         in_valid = 1'b1;
         in_a     = av[k];
         in_b     = bv[k];
         @(negedge clk);
         in_valid = 1'b0;
         in_a     = 8'hEE;
         in_b     = 8'hEE;
         @(negedge clk);
      end
      checks++; if (A_VEC !== exp_a) begin errors++; $display("FAIL gap_a_vec: got %h required %h", A_VEC[63:0], exp_a[63:0]); end
      checks++; if (B_VEC !== exp_b) begin errors++; $display("FAIL gap_b_vec: got %h required %h", B_VEC[63:0], exp_b[63:0]); end
      wait_result(cyc);
      checks++; if (res_data !== 24'(exp_sum)) begin errors++; $display("FAIL gap_res_data: got %0d required %0d", res_data, exp_sum); end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_lane_order();
      test_backpressure();
      test_reset_mid_frame();
      test_short_frame();
      test_gapped();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
